// File: rtl/lcd_panel_pkg.sv
// Shared definitions for the LCD panel controller: FSM states, per-page
// sub-steps, panel command bytes and a width helper.
package lcd_panel_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ERASE,
    ST_IDLE,
    ST_REQ,
    ST_READ
  } state_e;

  // Sub-step within one page: address the page, home the column, then stream.
  typedef enum logic [1:0] {
    PH_SETPAGE,
    PH_SETY,
    PH_DATA
  } phase_e;

  localparam logic [7:0] CMD_DISPLAY_ON = 8'h3F;
  localparam logic [7:0] CMD_SET_Y      = 8'h40;
  localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/lcd_panel_ctrl_if.sv
// Source-memory side of the LCD panel controller: page request/ack handshake,
// {image,cs,page} address, column index and the streamed byte.
interface lcd_panel_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned COL_W  = 6
);
  logic              data_req;
  logic              data_ack;
  logic [7:0]        data;
  logic [ADDR_W-1:0] addr;
  logic [COL_W-1:0]  col;

  modport master (output data_req, addr, col, input data_ack, data);
  modport slave  (input data_req, addr, col, output data_ack, data);
endinterface

// File: rtl/lcd_step_timer.sv
// Panel enable generator: lcd_en toggles every clk; the controller takes one
// step in each cycle where lcd_en is low.
module lcd_step_timer (
  input  logic clk,
  input  logic rst,
  output logic lcd_en,
  output logic step_en
);
  logic en_q, en_d;

  // next enable level is simply the inverse of the current one
  always_comb begin
    en_d = ~en_q;
  end

  // enable register, low out of reset
  always_ff @(posedge clk) begin
    if (rst) en_q <= 1'b0;
    else     en_q <= en_d;
  end

  assign lcd_en  = en_q;
  assign step_en = ~en_q;
endmodule

// File: rtl/lcd_panel_ctrl.sv
// LCD panel controller: initialises and erases a multi-chip graphic panel,
// then on request streams image pages from a source memory to the panel.
// Optional macro LCD_PANEL_CTRL_AUTOPLAY_EN: frames start after the idle
// period without waiting for start.
module lcd_panel_ctrl
  import lcd_panel_pkg::*;
#(
  parameter int unsigned NUM_CS      = 2,
  parameter int unsigned PAGES       = 8,
  parameter int unsigned COLS        = 64,
  parameter int unsigned NUM_IMAGES  = 9,
  parameter int unsigned IDLE_CYCLES = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  lcd_panel_ctrl_if.master  mem,
  output logic              done,
  output logic              busy,
  output logic              lcd_di,
  output logic              lcd_rw,
  output logic              lcd_en,
  output logic              lcd_rst,
  output logic [NUM_CS-1:0] lcd_cs,
  output logic [7:0]        lcd_data
);
  localparam int unsigned IMG_W  = clog2_min1(NUM_IMAGES);
  localparam int unsigned CS_W   = clog2_min1(NUM_CS);
  localparam int unsigned PG_W   = clog2_min1(PAGES);
  localparam int unsigned COL_W  = clog2_min1(COLS);
  localparam int unsigned IDLE_W = clog2_min1(IDLE_CYCLES + 1);

  localparam logic [IMG_W-1:0]  IMG_LAST = IMG_W'(NUM_IMAGES - 1);
  localparam logic [CS_W-1:0]   CS_LAST  = CS_W'(NUM_CS - 1);
  localparam logic [PG_W-1:0]   PG_LAST  = PG_W'(PAGES - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_CYCLES);

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [CS_W-1:0]     cs_q, cs_d;
  logic [PG_W-1:0]     page_q, page_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [IMG_W-1:0]    image_q, image_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                di_q, di_d;
  logic                rw_q, rw_d;
  logic [7:0]          bus_q, bus_d;
  logic [NUM_CS-1:0]   lcd_cs_q, lcd_cs_d;
  logic                done_q, done_d;

  logic step_en;
  logic go;
  logic cs_last, page_last, col_last;

  lcd_step_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .lcd_en  (lcd_en),
    .step_en (step_en)
  );

`ifdef LCD_PANEL_CTRL_AUTOPLAY_EN
  assign go = 1'b1;
`else
  assign go = start;
`endif

  assign cs_last   = (cs_q == CS_LAST);
  assign page_last = (page_q == PG_LAST);
  assign col_last  = (col_q == COL_LAST);

  // next-state, counters and panel bus; everything moves only on step cycles
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cs_d       = cs_q;
    page_d     = page_q;
    col_d      = col_q;
    image_d    = image_q;
    idle_cnt_d = idle_cnt_q;
    di_d       = di_q;
    rw_d       = rw_q;
    bus_d      = bus_q;
    lcd_cs_d   = lcd_cs_q;
    done_d     = 1'b0;
    if (step_en) begin
      di_d     = 1'b0;
      rw_d     = 1'b0;
      bus_d    = CMD_DISPLAY_ON;
      lcd_cs_d = NUM_CS'(1) << cs_q;
      case (state_q)
        ST_INIT: begin
          if (cs_last) begin
            cs_d    = '0;
            phase_d = PH_SETPAGE;
            state_d = ST_ERASE;
          end else begin
            cs_d = cs_q + CS_W'(1);
          end
        end
        ST_ERASE: begin
          case (phase_q)
            PH_SETPAGE: begin
              bus_d   = CMD_SET_PAGE | 8'(page_q);
              phase_d = PH_SETY;
            end
            PH_SETY: begin
              bus_d   = CMD_SET_Y;
              col_d   = '0;
              phase_d = PH_DATA;
            end
            default: begin
              di_d  = 1'b1;
              bus_d = 8'h00;
              if (col_last) begin
                col_d   = '0;
                phase_d = PH_SETPAGE;
                if (!page_last) begin
                  page_d = page_q + PG_W'(1);
                end else begin
                  page_d = '0;
                  if (!cs_last) begin
                    cs_d = cs_q + CS_W'(1);
                  end else begin
                    cs_d       = '0;
                    image_d    = '0;
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                  end
                end
              end else begin
                col_d = col_q + COL_W'(1);
              end
            end
          endcase
        end
        ST_IDLE: begin
          lcd_cs_d = '1;
          if ((idle_cnt_q >= IDLE_LIM) && go) begin
            idle_cnt_d = '0;
            cs_d       = '0;
            page_d     = '0;
            phase_d    = PH_SETPAGE;
            state_d    = ST_REQ;
          end else if (idle_cnt_q < IDLE_LIM) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
        ST_REQ: begin
          if (phase_q == PH_SETPAGE) begin
            if (mem.data_ack) begin
              bus_d   = CMD_SET_PAGE | 8'(page_q);
              phase_d = PH_SETY;
            end
          end else begin
            bus_d   = CMD_SET_Y;
            col_d   = '0;
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          di_d  = 1'b1;
          bus_d = mem.data;
          if (col_last) begin
            col_d   = '0;
            phase_d = PH_SETPAGE;
            state_d = ST_REQ;
            if (!page_last) begin
              page_d = page_q + PG_W'(1);
            end else begin
              page_d = '0;
              if (!cs_last) begin
                cs_d = cs_q + CS_W'(1);
              end else begin
                cs_d    = '0;
                image_d = (image_q == IMG_LAST) ? '0 : image_q + IMG_W'(1);
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      phase_q    <= PH_SETPAGE;
      cs_q       <= '0;
      page_q     <= '0;
      col_q      <= '0;
      image_q    <= '0;
      idle_cnt_q <= '0;
      di_q       <= 1'b0;
      rw_q       <= 1'b0;
      bus_q      <= 8'h00;
      lcd_cs_q   <= '1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cs_q       <= cs_d;
      page_q     <= page_d;
      col_q      <= col_d;
      image_q    <= image_d;
      idle_cnt_q <= idle_cnt_d;
      di_q       <= di_d;
      rw_q       <= rw_d;
      bus_q      <= bus_d;
      lcd_cs_q   <= lcd_cs_d;
      done_q     <= done_d;
    end
  end

  // request is a decode of registered state, so reset drops it at the next edge
  assign mem.data_req = (state_q == ST_REQ) && (phase_q == PH_SETPAGE);
  assign mem.addr     = {image_q, cs_q, page_q};
  assign mem.col      = col_q;

  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);
  assign lcd_di   = di_q;
  assign lcd_rw   = rw_q;
  assign lcd_data = bus_q;
  assign lcd_cs   = lcd_cs_q;
  assign lcd_rst  = ~rst;
endmodule

// File: tb/tb_lcd_panel_ctrl.sv
// Testbench for lcd_panel_ctrl: random image memory and random ack delays,
// expected panel command stream built from nested image/chip/page/column loops.
module tb_lcd_panel_ctrl;
  localparam int NCS   = 2;
  localparam int NPG   = 8;
  localparam int NCOL  = 64;
  localparam int NIMG  = 9;
  localparam int IDLE  = 40;
  localparam int CS_W  = 1;
  localparam int PG_W  = 3;
  localparam int AW    = 8;
  localparam int CW    = 6;
  localparam logic [NCS-1:0] ALL_CS = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic done, busy, lcd_di, lcd_rw, lcd_en, lcd_rst;
  logic [NCS-1:0] lcd_cs;
  logic [7:0] lcd_data;

  lcd_panel_ctrl_if #(.ADDR_W(AW), .COL_W(CW)) mif ();

  lcd_panel_ctrl #(
    .NUM_CS(NCS), .PAGES(NPG), .COLS(NCOL), .NUM_IMAGES(NIMG), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mem(mif),
    .done(done), .busy(busy), .lcd_di(lcd_di), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_rst(lcd_rst), .lcd_cs(lcd_cs), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int img   = 0;
  logic [7:0] mem_img [NIMG][NCS][NPG][NCOL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCS-1:0] oh(input int c);
    logic [NCS-1:0] r;
    r = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  // advance to just after the next step edge (edge where lcd_en was low)
  task automatic step();
    int g = 0;
    while (lcd_en !== 1'b0) begin
      g++;
      if (g > 3) begin
        bad++;
        $display("FAIL step_align: lcd_en=%b want 0 within 3 cycles", lcd_en);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "lcd_en not toggling");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("en_toggle", lcd_en, 1);
  endtask

  task automatic exp_step(input string tag, input logic di, input logic [7:0] d,
                          input logic [NCS-1:0] cs);
    step();
    chk(tag, {lcd_di, lcd_rw, lcd_data, lcd_cs}, {di, 1'b0, d, cs});
  endtask

  // n idle steps; the last one is the transition into the page request
  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) begin
      mif.data_ack = 1'($urandom);
      exp_step("idle_bus", 1'b0, 8'h3F, ALL_CS);
      chk("idle_req", mif.data_req, (i == n - 1) ? 1 : 0);
      chk("idle_busy", busy, (i == n - 1) ? 1 : 0);
    end
  endtask

  task automatic run_frame(input int delay_pg, input bit abort_en, output bit aborted);
    int d;
    aborted = 1'b0;
    for (int c = 0; c < NCS; c++) begin
      for (int p = 0; p < NPG; p++) begin
        chk("req_addr", mif.addr, (img << (CS_W + PG_W)) | (c << PG_W) | p);
        chk("req_high", mif.data_req, 1);
        d = (c * NPG + p == delay_pg) ? 7 : int'($urandom_range(0, 2));
        mif.data_ack = 1'b0;
        for (int i = 0; i < d; i++) begin
          exp_step("req_wait", 1'b0, 8'h3F, oh(c));
          chk("req_hold", mif.data_req, 1);
        end
        mif.data_ack = 1'b1;
        exp_step("set_page", 1'b0, 8'hB8 | 8'(p), oh(c));
        chk("req_drop", mif.data_req, 0);
        mif.data_ack = 1'($urandom);
        exp_step("set_y", 1'b0, 8'h40, oh(c));
        for (int k = 0; k < NCOL; k++) begin
          chk("rd_col", mif.col, k);
          if (abort_en && c == 0 && p == 3 && k == 20) begin
            rst = 1'b1;
            #1;
            chk("rst_comb", lcd_rst, 0);
            @(posedge clk);
            #1;
            chk("rst_req", mif.data_req, 0);
            chk("rst_busy", busy, 1);
            chk("rst_cs", lcd_cs, ALL_CS);
            chk("rst_bus", {lcd_di, lcd_rw, lcd_data}, 0);
            chk("rst_en", lcd_en, 0);
            chk("rst_addr", mif.addr, 0);
            chk("rst_colz", mif.col, 0);
            chk("rst_done", done, 0);
            aborted = 1'b1;
            return;
          end
          mif.data = mem_img[img][c][p][k];
          mif.data_ack = 1'($urandom);
          exp_step("rd_wr", 1'b1, mem_img[img][c][p][k], oh(c));
        end
        if (c == NCS - 1 && p == NPG - 1) begin
          chk("done_pulse", done, 1);
          chk("end_busy", busy, 0);
          @(posedge clk);
          #1;
          chk("done_once", done, 0);
        end else begin
          chk("done_early", done, 0);
        end
      end
    end
    img = (img + 1) % NIMG;
  endtask

  initial begin
    bit ab;
    for (int i = 0; i < NIMG; i++)
      for (int c = 0; c < NCS; c++)
        for (int p = 0; p < NPG; p++)
          for (int k = 0; k < NCOL; k++)
            mem_img[i][c][p][k] = 8'($urandom);
    mif.data_ack = 1'b0;
    mif.data = 8'h00;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req0", mif.data_req, 0);
    chk("rst_done0", done, 0);
    chk("rst_busy0", busy, 1);
    chk("rst_en0", lcd_en, 0);
    chk("rst_bus0", {lcd_di, lcd_rw, lcd_data}, 0);
    chk("rst_cs0", lcd_cs, ALL_CS);
    chk("rst_lrst0", lcd_rst, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_lrst", lcd_rst, 1);

    // display-on to each chip, then erase every page of every chip
    for (int c = 0; c < NCS; c++) exp_step("init_on", 1'b0, 8'h3F, oh(c));
    for (int c = 0; c < NCS; c++)
      for (int p = 0; p < NPG; p++) begin
        exp_step("erase_pg", 1'b0, 8'hB8 | 8'(p), oh(c));
        exp_step("erase_y", 1'b0, 8'h40, oh(c));
        for (int k = 0; k < NCOL; k++) exp_step("erase_wr", 1'b1, 8'h00, oh(c));
      end
    chk("erase_end_busy", busy, 0);

`ifdef LCD_PANEL_CTRL_AUTOPLAY_EN
    start = 1'b0;
    idle_wait(IDLE + 1);
`else
    start = 1'b0;
    for (int i = 0; i < IDLE + 20; i++) begin
      mif.data_ack = 1'($urandom);
      exp_step("nostart_bus", 1'b0, 8'h3F, ALL_CS);
      chk("nostart_req", mif.data_req, 0);
    end
    start = 1'b1;
    idle_wait(1);
`endif
    start = 1'b1;
    run_frame(2, 1'b0, ab);
    for (int f = 1; f < 10; f++) begin
      idle_wait(IDLE + 1);
      run_frame(-1, 1'b0, ab);
    end

    // abort mid-frame, then the init/erase sequence must restart
    idle_wait(IDLE + 1);
    run_frame(-1, 1'b1, ab);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel2_lrst", lcd_rst, 1);
    for (int c = 0; c < NCS; c++) exp_step("reinit_on", 1'b0, 8'h3F, oh(c));
    exp_step("reerase_pg", 1'b0, 8'hB8, oh(0));
    exp_step("reerase_y", 1'b0, 8'h40, oh(0));
    chk("reerase_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_panel_ctrl.md
LCD_PANEL_CTRL -- requirements
Module: lcd_panel_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_CS, 2, number of controller chips (one chip select each, 64-column halves).
- PAGES, 8, pages (8-pixel rows) per chip.
- COLS, 64, columns per page.
- NUM_IMAGES, 9, images in the source memory.
- IDLE_CYCLES, 10000, minimum FSM steps spent in IDLE before a frame starts.
REQ-002 Ports SHALL be, one per line:
- clk, in, 1, the single clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, frame start request (level).
- data_req, out, 1, page request to the source memory.
- data_ack, in, 1, page ready from the source memory.
- data, in, 8, streamed column byte.
- addr, out, IMG_W+CS_W+PG_W, {image, cs, page}; widths are clog2 of NUM_IMAGES, NUM_CS and PAGES (minimum 1 each).
- col, out, clog2(COLS), index of the byte expected on data.
- done, out, 1, one-clk pulse at frame end.
- busy, out, 1, high outside IDLE.
- lcd_di, lcd_rw, lcd_en, lcd_rst, out, 1 each, panel control lines.
- lcd_cs, out, NUM_CS, one-hot chip select.
- lcd_data, out, 8, panel data bus.

Function
REQ-003 lcd_en SHALL toggle every clk; the FSM SHALL advance one step only in cycles where lcd_en==0, and {lcd_di,lcd_rw,lcd_data,lcd_cs} SHALL register at that same edge.
REQ-004 Commands SHALL encode as follows; in every non-command step the bus SHALL carry display-on.
- display-on: di=0 rw=0 0x3F.
- set-Y: 0x40|y.
- set-page: 0xB8|p.
- data write: di=1 rw=0 byte.
REQ-005 States SHALL be INIT, ERASE, IDLE, REQ, READ.
REQ-006 INIT SHALL issue display-on to every chip in turn, then enter ERASE.
REQ-007 ERASE SHALL, per chip and per page, issue set-page, then set-Y 0, then COLS writes of 0x00. After the last chip and page it SHALL set image=0 and enter IDLE.
REQ-008 IDLE SHALL count steps. When count>=IDLE_CYCLES and start==1 it SHALL clear the count, set cs=0 and page=0, and enter REQ.
REQ-009 REQ SHALL hold data_req=1. On the step where data_ack==1 it SHALL drop data_req, issue set-page, then set-Y 0, and enter READ.
REQ-010 READ SHALL issue COLS data writes of data, with col counting 0..COLS-1 and data sampled at each step edge.
REQ-011 After the last byte of a page, READ SHALL advance page, then cs (page wrap to 0), then image; any incomplete frame SHALL return to REQ.
REQ-012 Frame end SHALL pulse done for exactly one clk and return to IDLE. image SHALL wrap from NUM_IMAGES-1 to 0.
REQ-013 data_ack outside REQ SHALL be ignored. start held high SHALL start back-to-back frames, each separated by IDLE_CYCLES steps.
REQ-014 lcd_cs SHALL be one-hot on the current chip in ERASE/REQ/READ and all-ones in IDLE.

Reset
REQ-015 rst SHALL apply at the clk edge. Reset values: state=INIT, all counters 0, data_req=0, done=0, busy=1, lcd_en=0, lcd_di=0, lcd_rw=0, lcd_data=0x00, lcd_cs=all-ones.
REQ-016 lcd_rst SHALL be ~rst combinationally. Reset mid-frame SHALL abort the frame, drop data_req the next cycle, and re-run INIT and ERASE.

Configuration
REQ-017 With macro LCD_PANEL_CTRL_AUTOPLAY_EN defined, IDLE SHALL start the next frame after IDLE_CYCLES steps regardless of start. Without it, start==1 SHALL be required.

Structure
REQ-018 A shared package lcd_panel_pkg SHALL hold the state enumeration and the command constants (display-on, set-Y base, set-page base).
REQ-019 One sub-module, lcd_step_timer, SHALL generate lcd_en and the step-enable strobe.

Verification
REQ-020 Default parameters, reset then release -> NUM_CS display-on steps; 2*8*(2+64) erase steps; lcd_rst tracks ~rst.
REQ-021 start=1, data_ack tied 1, data=col -> 16 page requests with addr {0,cs,page} in order; bytes 0..63 per page; one done pulse; image=1 afterwards.
REQ-022 data_ack delayed 7 steps -> data_req held, no data writes during the delay, then normal stream.
REQ-023 9 frames -> image wraps 8->0; addr image field 0 on frame 10.
REQ-024 rst asserted at page 3 byte 20 -> data_req low next clk; INIT sequence restarts.
REQ-025 AUTOPLAY_EN defined, start=0 -> frame starts after 10000 idle steps; undefined -> no frame.
